regfile_scan: RTL and testbench
===============================

Name: regfile_scan

Overview:
- Debug read-out engine for the 8-bit register file.
- On `start`, it borrows the register file's A read port from the CPU using a req/gnt pair.
- It walks registers `FIRST_REG`..`LAST_REG` in order and streams each value out over a valid/ready byte interface. Each byte is tagged with its register index.
- It sits between the register file's read side and the debug/host link. It is the reader counterpart of the register file write path.

Parameters:
- `DW`, 8: register data width.
- `AW`, 4: register select width (16 registers).
- `FIRST_REG`, 1: first index scanned. r0 is hardwired zero, so it is skipped by default.
- `LAST_REG`, 15: last index scanned. Must satisfy `FIRST_REG <= LAST_REG <= 2**AW-1`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that requests a full scan. Ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final byte handshake.
- `port_req`  out  1  request for ownership of the register file A read port.
- `port_gnt`  in  1  CPU grants the port (CPU stalled). Level signal.
- `rf_sel`  out  AW  register select driven onto the port's `asel` while owned.
- `rf_data`  in  DW  combinational read data from the port (`aout`).
- `out_data`  out  DW  captured register value.
- `out_idx`  out  AW  register index of `out_data`.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready. A transfer occurs when `out_valid && out_ready`.
- `out_last`  out  1  marks the final byte of a scan, qualified by `out_valid`.

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0. FSM enters IDLE and the index counter is cleared.
- FSM states:
  - IDLE: on `start`, load `idx=FIRST_REG`, go to REQ. `busy` goes high the next cycle.
  - REQ: assert `port_req`. When `port_gnt`=1, go to ADDR.
  - ADDR: drive `rf_sel=idx` (registered). If `port_gnt` is still 1, go to CAPT; if it has dropped, go to REQ.
  - CAPT: sample `rf_data` into `out_data` and set `out_idx=idx` and `out_valid=1`. Set `out_last=1` if `idx==LAST_REG`. Go to SEND.
  - SEND: hold `out_data`, `out_idx` and `out_last` stable until `out_ready`. On the handshake, `out_valid` drops the next cycle. If `idx==LAST_REG`, go to DONE; otherwise `idx++` and return to ADDR, or to REQ if `port_gnt`=0.
  - DONE: pulse `done` for one cycle, drop `port_req` and `busy`, return to IDLE.
- `port_req` stays high from REQ through SEND. The port is not released between registers, so the CPU stays stalled for the whole scan.
- Back-pressure: the port remains held while waiting on `out_ready`.
- `rf_sel` is driven only in ADDR/CAPT/SEND. It is 0 otherwise, so the port defaults to r0.
- Latency with `port_gnt` and `out_ready` tied high: first `out_valid` appears 4 cycles after `start` (IDLE→REQ→ADDR→CAPT→SEND). Each subsequent byte follows every 3 cycles.
- Grant lost during ADDR: the current index is re-read after re-grant, so no skip and no duplicate.
- Grant lost during SEND: the already captured byte is still delivered. The next read waits in REQ.
- `start` while `busy`: ignored, with no restart and no queuing.
- `FIRST_REG == LAST_REG`: exactly one byte is sent, with `out_last=1`.
- Index arithmetic is AW-bit. There is no wrap, because termination is on equality with `LAST_REG`.
- Reset mid-scan: immediate abort. `port_req`, `out_valid` and `busy` go to 0 asynchronously, and no `done` is produced.

Optional Feature:
- `REGFILE_SCAN_CHECKSUM_EN`: after `LAST_REG`'s byte, one extra byte is sent. Its `out_data` is the XOR of all scanned values and its `out_idx` is 0. `out_last` moves onto this checksum byte.
- The checksum is produced from an internal accumulator. The port is not read for it, and `port_req` drops once the `LAST_REG` byte is captured.
- Without the macro: there is no accumulator, and `out_last` is on the `LAST_REG` byte.

Test Plan:
- Load r1..r15 with 0x11*k (r1=0x11 … r15=0xFF); `port_gnt` and `out_ready` tied high; `start` → 15 bytes, idx 1..15, data 0x11..0xFF, `out_last` only on idx 15, `done` pulse; first valid 4 cycles after `start`. With the macro, a 16th byte idx 0, data 0x11^0x22^…^0xFF, carries `out_last` instead.
- `port_gnt` held low 10 cycles after `start` → `port_req`=1 throughout, no `out_valid` until the grant; scan then completes identically.
- Drop `port_gnt` for 3 cycles while in ADDR for idx 5 → idx 5 is re-read after the grant returns, and the stream is still exactly idx 1..15 with no gap or duplicate.
- `out_ready` low 8 cycles on idx 7 → `out_data`/`out_idx` stable at r7 value/7 for all 8 cycles; `port_req` stays 1.
- `start` pulsed again mid-scan at idx 9 → ignored; a single `done`; total byte count 15.
- Assert `rst` during SEND of idx 4 → `out_valid`, `port_req` and `busy` go 0 without waiting for `clk`; no `done`; a new `start` rescans from idx 1.

Source files
------------

// File: rtl/regfile_scan.sv
// Debug read-out engine: borrows the register file A read port and streams
// registers FIRST_REG..LAST_REG as index-tagged bytes. Optional: REGFILE_SCAN_CHECKSUM_EN.
module regfile_scan #(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_portReq,
  input  logic          i_portGnt,
  output logic [AW-1:0] o_rfSel,
  input  logic [DW-1:0] i_rfData,
  output logic [DW-1:0] o_outData,
  output logic [AW-1:0] o_outIdx,
  output logic          o_outValid,
  input  logic          i_outReady,
  output logic          o_outLast
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(FIRST_REG);
  localparam logic [AW-1:0] LAST_IDX  = AW'(LAST_REG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_CAPT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idxNext;
  logic [AW-1:0] r_rfSel;
  logic [AW-1:0] w_selNext;
  logic [DW-1:0] r_outData;
  logic [AW-1:0] r_outIdx;
  logic          r_outValid;
  logic          r_outLast;
  logic          r_portReq;
  logic          r_busy;
  logic          r_done;
  logic          w_load;
  logic          w_capt;
  logic          w_adv;
  logic          w_reqNext;
  logic          w_isLast;
  logic          w_xfer;

  assign w_isLast = (r_idx == LAST_IDX);
  assign w_xfer   = r_outValid && i_outReady;

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_capt      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_nextState = ST_REQ;
          w_load      = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_portGnt) w_nextState = ST_ADDR;
      end
      // A grant lost while addressing re-requests without advancing the index.
      ST_ADDR: begin
        w_nextState = i_portGnt ? ST_CAPT : ST_REQ;
      end
      ST_CAPT: begin
        w_capt      = 1'b1;
        w_nextState = ST_SEND;
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (w_isLast) begin
`ifdef REGFILE_SCAN_CHECKSUM_EN
            w_nextState = ST_CSUM;
`else
            w_nextState = ST_DONE;
`endif
          end else begin
            w_adv       = 1'b1;
            w_nextState = i_portGnt ? ST_ADDR : ST_REQ;
          end
        end
      end
      ST_CSUM: begin
        if (w_xfer) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_idxNext = r_idx;
    if (w_load) begin
      w_idxNext = FIRST_IDX;
    end else if (w_adv) begin
      w_idxNext = r_idx + AW'(1);
    end
    w_reqNext = (w_nextState == ST_REQ)  || (w_nextState == ST_ADDR) ||
                (w_nextState == ST_CAPT) || (w_nextState == ST_SEND);
`ifdef REGFILE_SCAN_CHECKSUM_EN
    // The final data byte is already captured, so the CPU can resume early.
    if ((w_nextState == ST_SEND) && (w_idxNext == LAST_IDX)) w_reqNext = 1'b0;
`endif
    w_selNext = '0;
    if (w_reqNext && (w_nextState != ST_REQ)) w_selNext = w_idxNext;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rfSel   <= '0;
      r_portReq <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_idxNext;
      r_rfSel   <= w_selNext;
      r_portReq <= w_reqNext;
      r_busy    <= (w_nextState != ST_IDLE) && (w_nextState != ST_DONE);
      r_done    <= (w_nextState == ST_DONE);
    end
  end

`ifdef REGFILE_SCAN_CHECKSUM_EN
  logic [DW-1:0] r_csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= '0;
    end else if (w_load) begin
      r_csum <= '0;
    end else if (w_capt) begin
      r_csum <= r_csum ^ i_rfData;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outData  <= '0;
      r_outIdx   <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_capt) begin
      r_outData  <= i_rfData;
      r_outIdx   <= r_idx;
      r_outValid <= 1'b1;
`ifdef REGFILE_SCAN_CHECKSUM_EN
      r_outLast  <= 1'b0;
`else
      r_outLast  <= w_isLast;
`endif
    end else if (w_xfer) begin
`ifdef REGFILE_SCAN_CHECKSUM_EN
      if ((r_state == ST_SEND) && w_isLast) begin
        r_outData  <= r_csum;
        r_outIdx   <= '0;
        r_outValid <= 1'b1;
        r_outLast  <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
        r_outLast  <= 1'b0;
      end
`else
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
`endif
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_portReq  = r_portReq;
  assign o_rfSel    = r_rfSel;
  assign o_outData  = r_outData;
  assign o_outIdx   = r_outIdx;
  assign o_outValid = r_outValid;
  assign o_outLast  = r_outLast;

endmodule

// File: tb/tb_regfile_scan.sv
// Scoreboard bench for regfile_scan: a modelled register file feeds the port
// and expected bytes are queued when a scan is started.
module tb_regfile_scan;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
    logic       last;
  } expByte_t;

`ifdef REGFILE_SCAN_CHECKSUM_EN
  localparam int NBYTES = 16;
`else
  localparam int NBYTES = 15;
`endif

  logic       clock;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       portReq;
  logic       portGnt;
  logic [3:0] rfSel;
  logic [7:0] rfData;
  logic [7:0] outData;
  logic [3:0] outIdx;
  logic       outValid;
  logic       outReady;
  logic       outLast;

  logic [7:0] regFile [16];
  expByte_t   expQ [$];
  int         checks = 0;
  int         errors = 0;
  int         doneCount = 0;
  int         byteCount = 0;
  int         cycCount = 0;
  int         startCyc = 0;

  regfile_scan dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_portReq  (portReq),
    .i_portGnt  (portGnt),
    .o_rfSel    (rfSel),
    .i_rfData   (rfData),
    .o_outData  (outData),
    .o_outIdx   (outIdx),
    .o_outValid (outValid),
    .i_outReady (outReady),
    .o_outLast  (outLast)
  );

  assign rfData = regFile[rfSel];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycCount <= cycCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every handshake pops the oldest expected byte and compares it.
  always @(negedge clock) begin
    expByte_t e;
    if (!reset && outValid && outReady) begin
      byteCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedByte", {28'd0, outIdx}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("outIdx", {28'd0, outIdx}, {28'd0, e.idx});
        checkOutput("outData", {24'd0, outData}, {24'd0, e.data});
        checkOutput("outLast", {31'd0, outLast}, {31'd0, e.last});
      end
    end
    if (!reset && done) doneCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit pushExpect);
    expByte_t e;
    logic [7:0] csum;
    csum = 8'h00;
    if (pushExpect) begin
      for (int k = 1; k <= 15; k++) begin
        e.idx  = 4'(k);
        e.data = regFile[k];
`ifdef REGFILE_SCAN_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (k == 15);
`endif
        expQ.push_back(e);
        csum = csum ^ regFile[k];
      end
`ifdef REGFILE_SCAN_CHECKSUM_EN
      e.idx  = 4'd0;
      e.data = csum;
      e.last = 1'b1;
      expQ.push_back(e);
`endif
    end
    startCyc = cycCount;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int d0;
    d0 = doneCount;
    for (int i = 0; i < budget && doneCount == d0; i++) waitCycles(1);
    checkOutput(tag, {31'd0, doneCount != d0}, 32'd1);
  endtask

  task automatic waitSel(input string tag, input logic [3:0] sel);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rfSel == sel && portReq) found = 1'b1;
      else waitCycles(1);
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: observed no finish, expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int d0, b0, badReq, sawValid, bad;
    bit found;
    for (int k = 0; k < 16; k++) regFile[k] = 8'(8'h11 * k);
    reset    = 1'b1;
    start    = 1'b0;
    portGnt  = 1'b1;
    outReady = 1'b1;
    waitCycles(3);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetPortReq", {31'd0, portReq}, 32'd0);
    checkOutput("resetValid", {31'd0, outValid}, 32'd0);
    checkOutput("resetRfSel", {28'd0, rfSel}, 32'd0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] scan with grant and ready held high");
    d0 = doneCount; b0 = byteCount;
    applyStimulus(1'b1);
    checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (outValid) break;
    end
    checkOutput("firstValidLatency", cycCount - startCyc, 32'd4);
    waitDone("scan1Done", 200);
    waitCycles(3);
    checkOutput("scan1DoneCount", doneCount - d0, 32'd1);
    checkOutput("scan1Bytes", byteCount - b0, NBYTES);
    checkOutput("scan1QueueEmpty", expQ.size(), 32'd0);
    checkOutput("scan1BusyLow", {31'd0, busy}, 32'd0);
    checkOutput("scan1ReqLow", {31'd0, portReq}, 32'd0);

    $display("[TB] grant withheld for 10 cycles");
    portGnt = 1'b0;
    b0 = byteCount; badReq = 0; sawValid = 0;
    applyStimulus(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!portReq) badReq++;
      if (outValid) sawValid++;
      waitCycles(1);
    end
    checkOutput("reqHeldNoGrant", badReq, 32'd0);
    checkOutput("validBeforeGrant", sawValid, 32'd0);
    portGnt = 1'b1;
    waitDone("scan2Done", 200);
    checkOutput("scan2Bytes", byteCount - b0, NBYTES);

    $display("[TB] grant dropped in ADDR for idx 5");
    waitCycles(2);
    b0 = byteCount;
    applyStimulus(1'b1);
    waitSel("findAddr5", 4'd5);
    portGnt = 1'b0;
    waitCycles(3);
    checkOutput("reqDuringGrantLoss", {31'd0, portReq}, 32'd1);
    portGnt = 1'b1;
    waitDone("scan3Done", 200);
    checkOutput("scan3Bytes", byteCount - b0, NBYTES);

    $display("[TB] back-pressure on idx 7");
    waitCycles(2);
    b0 = byteCount; bad = 0; found = 1'b0;
    applyStimulus(1'b1);
    waitSel("findAddr7", 4'd7);
    outReady = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (outValid) found = 1'b1;
    end
    checkOutput("validIdx7", {31'd0, found}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clock);
      if (outData !== 8'h77 || outIdx !== 4'd7 || !portReq || !outValid) bad++;
    end
    checkOutput("stallStable", bad, 32'd0);
    @(posedge clock); #1;
    outReady = 1'b1;
    waitDone("scan4Done", 200);
    checkOutput("scan4Bytes", byteCount - b0, NBYTES);

    $display("[TB] start re-pulsed mid-scan");
    waitCycles(2);
    d0 = doneCount; b0 = byteCount;
    applyStimulus(1'b1);
    waitSel("findAddr9", 4'd9);
    applyStimulus(1'b0);
    waitDone("scan5Done", 200);
    waitCycles(10);
    checkOutput("scan5DoneCount", doneCount - d0, 32'd1);
    checkOutput("scan5Bytes", byteCount - b0, NBYTES);
    checkOutput("scan5NoRestart", {31'd0, busy}, 32'd0);

    $display("[TB] reset during SEND of idx 4");
    d0 = doneCount; found = 1'b0;
    applyStimulus(1'b1);
    for (int i = 0; i < 200 && !found; i++) begin
      if (outValid && outIdx == 4'd4) found = 1'b1;
      else waitCycles(1);
    end
    checkOutput("findSend4", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("asyncValid", {31'd0, outValid}, 32'd0);
    checkOutput("asyncPortReq", {31'd0, portReq}, 32'd0);
    checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
    expQ.delete();
    waitCycles(2);
    reset = 1'b0;
    waitCycles(5);
    checkOutput("noDoneAfterAbort", doneCount - d0, 32'd0);
    b0 = byteCount;
    applyStimulus(1'b1);
    waitDone("scan6Done", 200);
    checkOutput("scan6Bytes", byteCount - b0, NBYTES);
    checkOutput("scan6QueueEmpty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
